// File: rtl/deinterleaver_rx_if.sv
// Handshake/bus bundle between the channel front end, the deinterleaver and the Hamming decoder.
interface deinterleaver_rx_if #(
  parameter int unsigned n          = 7,
  parameter int unsigned symbol_num = 4
);
  localparam int unsigned BLK_W = n * symbol_num;

  logic             en;
  logic             bit_i;
  logic             sync_i;
  logic             ready_i;
  logic             eno;
  logic [BLK_W-1:0] data_o;
  logic             ovf_o;

  modport master (output en, bit_i, sync_i, ready_i, input eno, data_o, ovf_o);
  modport slave  (input en, bit_i, sync_i, ready_i, output eno, data_o, ovf_o);
endinterface

// File: rtl/deinterleaver_rx.sv
// Block deinterleaver: serial interleaved bits in, restored n*symbol_num-bit block out (valid/ready).
// Optional DEINTERLEAVER_DROP_CNT_EN adds drop_cnt_o, a saturating count of dropped blocks.
module deinterleaver_rx #(
  parameter int unsigned n          = 7,
  parameter int unsigned symbol_num = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  deinterleaver_rx_if.slave bus
`ifdef DEINTERLEAVER_DROP_CNT_EN
  ,
  output logic [7:0]        drop_cnt_o
`endif
);
  localparam int unsigned BLK_W = n * symbol_num;
  localparam int unsigned COL_W = (symbol_num > 1) ? $clog2(symbol_num) : 1;
  localparam int unsigned ROW_W = (n > 1) ? $clog2(n) : 1;
  localparam int unsigned IDX_W = (BLK_W > 1) ? $clog2(BLK_W) : 1;

  logic [BLK_W-1:0] fill_buf;
  logic [BLK_W-1:0] fill_nxt_c;
  logic [BLK_W-1:0] data_q;
  logic [COL_W-1:0] col;
  logic [COL_W-1:0] col_base_c;
  logic [COL_W-1:0] col_nxt_c;
  logic [ROW_W-1:0] row;
  logic [ROW_W-1:0] row_base_c;
  logic [ROW_W-1:0] row_nxt_c;
  logic [IDX_W-1:0] wr_idx_c;
  logic             eno_q;
  logic             ovf_q;
  logic             last_c;
  logic             slot_free_c;

  // A sync restarts the position counters before the current bit is placed.
  always_comb begin
    col_base_c = bus.sync_i ? '0 : col;
    row_base_c = bus.sync_i ? '0 : row;
    col_nxt_c  = col_base_c;
    row_nxt_c  = row_base_c;
    wr_idx_c   = IDX_W'(IDX_W'(col_base_c) * IDX_W'(n) + IDX_W'(row_base_c));
    fill_nxt_c = fill_buf;
    last_c     = 1'b0;
    if (bus.en) begin
      fill_nxt_c[wr_idx_c] = bus.bit_i;
      if (col_base_c == COL_W'(symbol_num - 1)) begin
        col_nxt_c = '0;
        if (row_base_c == ROW_W'(n - 1)) begin
          row_nxt_c = '0;
          last_c    = !bus.sync_i;
        end else begin
          row_nxt_c = row_base_c + ROW_W'(1);
        end
      end else begin
        col_nxt_c = col_base_c + COL_W'(1);
      end
    end
  end

  assign slot_free_c = !eno_q || bus.ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_buf <= '0;
      col      <= '0;
      row      <= '0;
      data_q   <= '0;
      eno_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (bus.en) fill_buf <= fill_nxt_c;
      if (bus.en || bus.sync_i) begin
        col <= col_nxt_c;
        row <= row_nxt_c;
      end
      ovf_q <= last_c && !slot_free_c;
      if (last_c && slot_free_c) begin
        data_q <= fill_nxt_c;
        eno_q  <= 1'b1;
      end else if (eno_q && bus.ready_i) begin
        eno_q  <= 1'b0;
      end
    end
  end

  assign bus.eno    = eno_q;
  assign bus.data_o = data_q;
  assign bus.ovf_o  = ovf_q;

`ifdef DEINTERLEAVER_DROP_CNT_EN
  logic [7:0] drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else if (last_c && !slot_free_c && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
`endif
endmodule

// File: tb/tb_deinterleaver_rx.sv
// Directed scoreboard bench for deinterleaver_rx (default n=7, symbol_num=4).
module tb_deinterleaver_rx;
  localparam int unsigned NR    = 7;
  localparam int unsigned SYM   = 4;
  localparam int unsigned BLK_W = NR * SYM;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  int   ovf_seen = 0;
  logic hold_chk = 1'b0;
  logic [BLK_W-1:0] hold_val = '0;
  logic [BLK_W-1:0] sb[$];
  logic [BLK_W-1:0] sa, sb_blk, s6, y, z, junk;

  deinterleaver_rx_if #(.n(NR), .symbol_num(SYM)) bus ();

`ifdef DEINTERLEAVER_DROP_CNT_EN
  logic [7:0] drop_cnt_o;
  deinterleaver_rx #(.n(NR), .symbol_num(SYM)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .drop_cnt_o(drop_cnt_o));
`else
  deinterleaver_rx #(.n(NR), .symbol_num(SYM)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [BLK_W-1:0] deint(input logic [BLK_W-1:0] s);
    logic [BLK_W-1:0] r = '0;
    for (int k = 0; k < int'(BLK_W); k++) r[(k % SYM) * NR + k / SYM] = s[k];
    return r;
  endfunction

  function automatic logic [BLK_W-1:0] interleave(input logic [BLK_W-1:0] d);
    logic [BLK_W-1:0] r = '0;
    for (int k = 0; k < int'(BLK_W); k++) r[k] = d[(k % SYM) * NR + k / SYM];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [BLK_W-1:0] obs, input logic [BLK_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [BLK_W-1:0] s, input int len, input logic rdy_body,
                           input logic rdy_last, input int sync_at);
    for (int k = 0; k < len; k++) begin
      bus.en      = 1'b1;
      bus.bit_i   = s[k];
      bus.sync_i  = (k == sync_at);
      bus.ready_i = (k == len - 1) ? rdy_last : rdy_body;
      tick();
      if (bus.ovf_o) ovf_seen++;
      if (hold_chk) chk("hold_stable", bus.data_o, hold_val);
    end
    bus.en     = 1'b0;
    bus.sync_i = 1'b0;
    bus.bit_i  = 1'b0;
  endtask

  // Pops the next expected block when the DUT presents one.
  task automatic check_out(input string tag);
    logic [BLK_W-1:0] exp;
    chk({tag, "_eno"}, BLK_W'(bus.eno), BLK_W'(1));
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s: observed output with empty scoreboard expected none", tag);
    end else begin
      exp = sb.pop_front();
      chk(tag, bus.data_o, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.en = 1'b0; bus.bit_i = 1'b0; bus.sync_i = 1'b0; bus.ready_i = 1'b0;
    #3;
    chk("rst_eno", BLK_W'(bus.eno), '0);
    chk("rst_data", bus.data_o, '0);
    chk("rst_ovf", BLK_W'(bus.ovf_o), '0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // single bit k=1
    sb.push_back(28'h0000080);
    send_bits(BLK_W'(1) << 1, 28, 1'b1, 1'b1, -1);
    check_out("t1_k1");
    chk("t1_ovf", BLK_W'(bus.ovf_o), '0);
    tick();
    chk("t1_eno_drop", BLK_W'(bus.eno), '0);

    // corners
    sb.push_back(28'h0000002);
    send_bits(BLK_W'(1) << 4, 28, 1'b1, 1'b1, -1);
    check_out("t2_k4");
    tick();
    sb.push_back(28'h8000000);
    send_bits(BLK_W'(1) << 27, 28, 1'b1, 1'b1, -1);
    check_out("t2_k27");
    tick();

    // round trip
    sb.push_back(28'hABCDEF1);
    send_bits(interleave(28'hABCDEF1), 28, 1'b1, 1'b1, -1);
    check_out("t3_roundtrip");
    tick();

    // backpressure: second block dropped, first held
    sa = BLK_W'($urandom); sb_blk = BLK_W'($urandom);
    sb.push_back(deint(sa));
    send_bits(sa, 28, 1'b0, 1'b0, -1);
    check_out("t4_first");
    hold_val = deint(sa); hold_chk = 1'b1; ovf_seen = 0;
    send_bits(sb_blk, 28, 1'b0, 1'b0, -1);
    hold_chk = 1'b0;
    chk("t4_ovf_pulse", BLK_W'(bus.ovf_o), BLK_W'(1));
    chk("t4_eno_held", BLK_W'(bus.eno), BLK_W'(1));
    tick();
    chk("t4_ovf_end", BLK_W'(bus.ovf_o), '0);
    chk("t4_ovf_count", BLK_W'(ovf_seen), BLK_W'(1));
`ifdef DEINTERLEAVER_DROP_CNT_EN
    chk("t4_drop_cnt", BLK_W'(drop_cnt_o), BLK_W'(1));
`endif
    bus.ready_i = 1'b1;
    tick();
    chk("t4_eno_after_xfer", BLK_W'(bus.eno), '0);
    chk("t4_data_kept", bus.data_o, deint(sa));

    // back-to-back transfer and completion
    sa = BLK_W'($urandom); sb_blk = BLK_W'($urandom);
    sb.push_back(deint(sa));
    send_bits(sa, 28, 1'b0, 1'b0, -1);
    check_out("t5_first");
    sb.push_back(deint(sb_blk));
    ovf_seen = 0;
    send_bits(sb_blk, 28, 1'b0, 1'b1, -1);
    check_out("t5_b2b");
    chk("t5_no_ovf", BLK_W'(ovf_seen), '0);
    tick();
    chk("t5_eno_drop", BLK_W'(bus.eno), '0);

    // sync with en discards a partial block
    junk = BLK_W'($urandom); s6 = BLK_W'($urandom);
    send_bits(junk, 10, 1'b1, 1'b1, -1);
    chk("t6_no_partial", BLK_W'(bus.eno), '0);
    sb.push_back(deint(s6));
    send_bits(s6, 28, 1'b1, 1'b1, 0);
    check_out("t6_sync");
    tick();

    // sync on the last bit wins over completion
    y = BLK_W'($urandom); z = BLK_W'($urandom);
    ovf_seen = 0;
    send_bits(y, 28, 1'b1, 1'b1, 27);
    chk("t6_sync_last_eno", BLK_W'(bus.eno), '0);
    chk("t6_sync_last_ovf", BLK_W'(ovf_seen), '0);
    z[0] = y[27];
    sb.push_back(deint(z));
    send_bits(z >> 1, 27, 1'b1, 1'b1, -1);
    check_out("t6_after_sync_last");
    tick();

    // reset mid-block clears held output asynchronously
    sa = BLK_W'($urandom) | BLK_W'(1);
    sb.push_back(deint(sa));
    send_bits(sa, 28, 1'b0, 1'b0, -1);
    check_out("t6_held");
    send_bits(junk, 5, 1'b0, 1'b0, -1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_eno", BLK_W'(bus.eno), '0);
    chk("t6_rst_data", bus.data_o, '0);
    tick();
    @(negedge clk); rst_n = 1'b1; bus.ready_i = 1'b1;
    tick();
    s6 = BLK_W'($urandom);
    sb.push_back(deint(s6));
    send_bits(s6, 28, 1'b1, 1'b1, -1);
    check_out("t6_post_reset");
    tick();
    chk("t6_final_eno", BLK_W'(bus.eno), '0);
    chk("sb_drained", BLK_W'(sb.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
